// File: rtl/regfile_dump_ctrl_if.sv
// Handshake/bus bundle between the dump sequencer, pipeline, register file and debug TX.
interface regfile_dump_ctrl_if #(
  parameter int unsigned NBITS   = 5,
  parameter int unsigned NB_DATA = 32
);
  logic               i_pipe_halted;
  logic               i_dump_req;
  logic [NBITS-1:0]   i_pipe_addr;
  logic [NB_DATA-1:0] i_rf_data;
  logic               i_ready;
  logic [NBITS-1:0]   o_rf_rd_addr;
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               o_busy;
  logic               o_done;
  logic               o_abort;

  // Environment side: drives requests, RF data and ready; observes the dump stream.
  modport master (
    output i_pipe_halted, i_dump_req, i_pipe_addr, i_rf_data, i_ready,
    input  o_rf_rd_addr, o_data, o_valid, o_busy, o_done, o_abort
  );

  // Sequencer side.
  modport slave (
    input  i_pipe_halted, i_dump_req, i_pipe_addr, i_rf_data, i_ready,
    output o_rf_rd_addr, o_data, o_valid, o_busy, o_done, o_abort
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer: borrows the RF read port while the pipeline is
// halted and streams registers 0..N_REGS-1 over a valid/ready handshake.
module regfile_dump_ctrl #(
  parameter int unsigned NBITS   = 5,
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned N_REGS  = 32
) (
  input logic                i_clk,
  input logic                i_rst_n,
  regfile_dump_ctrl_if.slave bus
);

  localparam logic [NBITS-1:0] LAST_IDX = NBITS'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e             state_q;
  logic [NBITS-1:0]   cnt_q;
  logic [NB_DATA-1:0] data_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               abort_q;
  logic               halted;
  logic               in_dump;

  assign halted  = bus.i_pipe_halted;
  // A dump in flight is cancelled whenever the pipeline leaves the halted state.
  assign in_dump = (state_q == ISSUE) || (state_q == CAPTURE) || (state_q == SEND);

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (in_dump && !halted) begin
        // Abort wins over any same-cycle ready.
        state_q <= IDLE;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        abort_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.i_dump_req && halted) begin
              state_q <= ISSUE;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ISSUE: begin
            state_q <= CAPTURE;
          end
          CAPTURE: begin
            data_q  <= bus.i_rf_data;
            valid_q <= 1'b1;
            state_q <= SEND;
          end
          SEND: begin
            if (bus.i_ready) begin
              valid_q <= 1'b0;
              if (cnt_q == LAST_IDX) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                cnt_q   <= cnt_q + NBITS'(1);
                state_q <= ISSUE;
              end
            end
          end
          DONE: begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read-port mux: pipeline owns the port only while idle.
  assign bus.o_rf_rd_addr = (state_q == IDLE) ? bus.i_pipe_addr : cnt_q;

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
  assign bus.o_abort = abort_q;

endmodule
